// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller: funct3 codes, error codes, FSM states
// and the request legality helpers used at accept time.
package data_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_PMP   = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // Stores only have signed encodings; loads additionally allow the unsigned byte/half forms.
   function automatic logic f3_illegal(input logic write, input logic [2:0] funct3);
      if (write)
         return !(funct3 inside {F3_B, F3_H, F3_W});
      return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_ctrl_lsu_align.sv
// Byte-lane alignment for the load/store path: store strobe and lane replication on one side,
// load byte extraction with sign/zero extension on the other. Purely combinational.
module lsu_align
   import data_mem_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      wstrb     = 4'b1111;
      wdata_rep = st_data;
      case (st_funct3)
         F3_B: begin
            wstrb     = 4'b0001 << st_off;
            wdata_rep = {4{st_data[7:0]}};
         end
         F3_H: begin
            wstrb     = 4'b0011 << st_off;
            wdata_rep = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   // The addressed byte/half is brought down to bit 0 before extension.
   always_comb begin
      shifted = ld_word >> {ld_off, 3'b000};
      ld_data = '0;
      case (ld_funct3)
         F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    ld_data = ld_word;
         F3_BU:   ld_data = {24'b0, shifted[7:0]};
         F3_HU:   ld_data = {16'b0, shifted[15:0]};
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with valid/ready request/response channels, sized RV32 accesses,
// error classification at accept and a configurable read latency; one request in flight at a time.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DEPTH        = 512,
   parameter int ADDR_W       = 11,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              pmp_deny,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              misaligned;
   logic              illegal;
   logic              out_of_range;
   logic [1:0]        req_err;
   logic [IDX_W-1:0]  req_idx;
   logic [3:0]        wstrb;
   logic [31:0]       wdata_rep;
   logic [31:0]       ld_data;
   logic              lat_write;
   logic [2:0]        lat_funct3;
   logic [1:0]        lat_off;
   logic [1:0]        lat_err;
   logic [31:0]       mem [DEPTH];
   logic [31:0]       pipe [READ_LATENCY];

   assign accept       = req_valid & req_ready;
   assign req_idx      = req_addr[IDX_W+1:2];
   assign misaligned   = f3_misaligned(req_funct3, req_addr[1:0]);
   assign illegal      = f3_illegal(req_write, req_funct3);
   assign out_of_range = 32'(req_addr[ADDR_W-1:2]) >= 32'(DEPTH);

   // Error priority: alignment/encoding beats range, range beats the PMP verdict.
   always_comb begin
      req_err = ERR_OK;
      if (misaligned || illegal)
         req_err = ERR_ALIGN;
      else if (out_of_range)
         req_err = ERR_RANGE;
      else if (pmp_deny)
         req_err = ERR_PMP;
   end

   lsu_align u_align (
      .st_funct3 (req_funct3),
      .st_off    (req_addr[1:0]),
      .st_data   (req_wdata),
      .wstrb     (wstrb),
      .wdata_rep (wdata_rep),
      .ld_funct3 (lat_funct3),
      .ld_off    (lat_off),
      .ld_word   (pipe[READ_LATENCY-1]),
      .ld_data   (ld_data)
   );

   // Stores commit at the accept edge, so a later reset cannot undo them.
   always_ff @(posedge clk) begin
      if (accept && req_write && req_err == ERR_OK) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b])
               mem[req_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !req_write && req_err == ERR_OK)
         pipe[0] <= mem[req_idx];
      for (int i = 1; i < READ_LATENCY; i++)
         pipe[i] <= pipe[i-1];
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == '0)
               state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Errors always take a single wait cycle regardless of the configured latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= (req_err == ERR_OK) ? CNT_LOAD : '0;
         else if (state == WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_write  <= 1'b0;
         lat_funct3 <= '0;
         lat_off    <= '0;
         lat_err    <= ERR_OK;
      end else if (accept) begin
         lat_write  <= req_write;
         lat_funct3 <= req_funct3;
         lat_off    <= req_addr[1:0];
         lat_err    <= req_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_rdata <= '0;
         resp_err   <= ERR_OK;
      end else if (state == WAIT && cnt == '0) begin
         resp_err   <= lat_err;
         resp_rdata <= (lat_err == ERR_OK && !lat_write) ? ld_data : '0;
      end else if (state == RESP && resp_ready) begin
         resp_rdata <= '0;
         resp_err   <= ERR_OK;
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed requests push expected responses, a negedge monitor
// compares each presented response (data, error, latency, stability) against the queue head.
module tb_data_mem_ctrl;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          lat;
      int          edge_idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_tb;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        pmp_deny;
   logic        resp_ready;
   logic [1:0]  sel;

   logic [3:0]  valid_v;
   logic [3:0]  ready_v;
   logic [3:0]  rvalid_v;
   logic [31:0] rdata_v [4];
   logic [1:0]  err_v [4];

   logic        cur_req_ready;
   logic        cur_resp_valid;
   logic [31:0] cur_rdata;
   logic [1:0]  cur_err;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   seen = 1'b0;
   int   lat_of [4] = '{1, 3, 8, 2};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign valid_v        = req_valid_tb ? (4'b0001 << sel) : 4'b0000;
   assign cur_req_ready  = ready_v[sel];
   assign cur_resp_valid = rvalid_v[sel];
   assign cur_rdata      = rdata_v[sel];
   assign cur_err        = err_v[sel];

   data_mem_ctrl #(.DEPTH(512), .ADDR_W(11), .READ_LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst), .req_valid(valid_v[0]), .req_ready(ready_v[0]),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr[10:0]),
      .req_wdata(req_wdata), .pmp_deny(pmp_deny), .resp_valid(rvalid_v[0]),
      .resp_ready(resp_ready), .resp_rdata(rdata_v[0]), .resp_err(err_v[0]));

   data_mem_ctrl #(.DEPTH(512), .ADDR_W(11), .READ_LATENCY(3)) u_lat3 (
      .clk(clk), .rst(rst), .req_valid(valid_v[1]), .req_ready(ready_v[1]),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr[10:0]),
      .req_wdata(req_wdata), .pmp_deny(pmp_deny), .resp_valid(rvalid_v[1]),
      .resp_ready(resp_ready), .resp_rdata(rdata_v[1]), .resp_err(err_v[1]));

   data_mem_ctrl #(.DEPTH(512), .ADDR_W(11), .READ_LATENCY(8)) u_lat8 (
      .clk(clk), .rst(rst), .req_valid(valid_v[2]), .req_ready(ready_v[2]),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr[10:0]),
      .req_wdata(req_wdata), .pmp_deny(pmp_deny), .resp_valid(rvalid_v[2]),
      .resp_ready(resp_ready), .resp_rdata(rdata_v[2]), .resp_err(err_v[2]));

   // A 256-word memory behind a 12-bit address so that byte address 0x800 is representable.
   data_mem_ctrl #(.DEPTH(256), .ADDR_W(12), .READ_LATENCY(2)) u_range (
      .clk(clk), .rst(rst), .req_valid(valid_v[3]), .req_ready(ready_v[3]),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .pmp_deny(pmp_deny), .resp_valid(rvalid_v[3]),
      .resp_ready(resp_ready), .resp_rdata(rdata_v[3]), .resp_err(err_v[3]));

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout required=event (t=%0t)", name, $time);
   endtask

   // Inputs change 1 time unit after posedge; the next posedge is the accept edge.
   task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [11:0] addr,
                                input logic [31:0] wd, input bit pmp, input logic [31:0] exp_rd,
                                input logic [1:0] exp_err, input bit push);
      int n = 0;
      while (!cur_req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cur_req_ready) begin
         failNow("req_ready_wait");
         return;
      end
      req_write    = wr;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wd;
      pmp_deny     = pmp;
      req_valid_tb = 1'b1;
      if (push)
         sb.push_back('{exp_rd, exp_err, (exp_err != 2'b00) ? 1 : lat_of[sel], cyc});
      @(posedge clk); #1;
      req_valid_tb = 1'b0;
      pmp_deny     = 1'b0;
   endtask

   task automatic storeOp(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] wd,
                          input bit pmp, input logic [1:0] exp_err);
      applyStimulus(1'b1, f3, addr, wd, pmp, 32'h0, exp_err, 1'b1);
   endtask

   task automatic loadOp(input logic [2:0] f3, input logic [11:0] addr, input bit pmp,
                         input logic [31:0] exp_rd, input logic [1:0] exp_err);
      applyStimulus(1'b0, f3, addr, 32'h0, pmp, exp_rd, exp_err, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         failNow("response_wait");
         sb.delete();
         seen = 1'b0;
      end
   endtask

   // Compares every cycle a response is presented, so a stalled response must also hold steady.
   always @(negedge clk) begin
      if (!rst && cur_resp_valid) begin
         if (sb.size() == 0) begin
            failNow("unexpected_response");
         end else begin
            if (!seen) begin
               seen = 1'b1;
               checkOutput("resp_latency", 32'(cyc - 1 - sb[0].edge_idx), 32'(sb[0].lat));
            end
            checkOutput("resp_rdata", cur_rdata, sb[0].rdata);
            checkOutput("resp_err", {30'b0, cur_err}, {30'b0, sb[0].err});
            if (resp_ready) begin
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; req_valid_tb = 1'b0; req_write = 1'b0; req_funct3 = LW;
      req_addr = '0; req_wdata = '0; pmp_deny = 1'b0; resp_ready = 1'b1; sel = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", {31'b0, cur_req_ready}, 32'd1);
      checkOutput("rst_resp_valid", {31'b0, cur_resp_valid}, 32'd0);
      checkOutput("rst_resp_rdata", cur_rdata, 32'd0);
      checkOutput("rst_resp_err", {30'b0, cur_err}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] basic store/load, latency 1");
      storeOp(LW, 12'h000, 32'h0000_0001, 1'b0, 2'b00);
      loadOp(LW, 12'h000, 1'b0, 32'h0000_0001, 2'b00);
      storeOp(LW, 12'h400, 32'h0000_0000, 1'b0, 2'b00);
      storeOp(LB, 12'h401, 32'h1234_56AB, 1'b0, 2'b00);
      loadOp(LW, 12'h400, 1'b0, 32'h0000_AB00, 2'b00);
      loadOp(LB, 12'h401, 1'b0, 32'hFFFF_FFAB, 2'b00);
      loadOp(LBU, 12'h401, 1'b0, 32'h0000_00AB, 2'b00);
      storeOp(LH, 12'h402, 32'hFFFF_BEEF, 1'b0, 2'b00);
      loadOp(LH, 12'h402, 1'b0, 32'hFFFF_BEEF, 2'b00);
      loadOp(LHU, 12'h402, 1'b0, 32'h0000_BEEF, 2'b00);
      loadOp(LW, 12'h400, 1'b0, 32'hBEEF_AB00, 2'b00);
      drain();

      $display("[TB] alignment, encoding and PMP errors");
      loadOp(LH, 12'h003, 1'b0, 32'h0, 2'b01);
      storeOp(LW, 12'h002, 32'hDEAD_BEEF, 1'b0, 2'b01);
      loadOp(3'b011, 12'h000, 1'b0, 32'h0, 2'b01);
      storeOp(3'b100, 12'h000, 32'hDEAD_BEEF, 1'b0, 2'b01);
      loadOp(LW, 12'h000, 1'b0, 32'h0000_0001, 2'b00);
      storeOp(LW, 12'h7FC, 32'hCAFE_F00D, 1'b0, 2'b00);
      loadOp(LW, 12'h7FC, 1'b0, 32'hCAFE_F00D, 2'b00);
      storeOp(LW, 12'h404, 32'h1357_9BDF, 1'b0, 2'b00);
      storeOp(LW, 12'h404, 32'h5555_5555, 1'b1, 2'b11);
      loadOp(LW, 12'h404, 1'b0, 32'h1357_9BDF, 2'b00);
      loadOp(LW, 12'h000, 1'b1, 32'h0, 2'b11);
      loadOp(LW, 12'h405, 1'b1, 32'h0, 2'b01);
      drain();

      $display("[TB] response backpressure");
      resp_ready = 1'b0;
      loadOp(LW, 12'h7FC, 1'b0, 32'hCAFE_F00D, 2'b00);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_req_ready", {31'b0, cur_req_ready}, 32'd0);
         checkOutput("stall_resp_valid", {31'b0, cur_resp_valid}, 32'd1);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      drain();
      @(posedge clk); #1;
      checkOutput("post_resp_rdata", cur_rdata, 32'd0);

      $display("[TB] latency sweep with back-to-back requests");
      for (int s = 1; s <= 2; s++) begin
         sel = 2'(s);
         @(posedge clk); #1;
         storeOp(LW, 12'h010, 32'h1122_3344, 1'b0, 2'b00);
         loadOp(LW, 12'h010, 1'b0, 32'h1122_3344, 2'b00);
         loadOp(LH, 12'h012, 1'b0, 32'h0000_1122, 2'b00);
         loadOp(LB, 12'h013, 1'b0, 32'h0000_0011, 2'b00);
         loadOp(LHU, 12'h010, 1'b0, 32'h0000_3344, 2'b00);
         storeOp(LH, 12'h011, 32'h0000_FFFF, 1'b0, 2'b01);
         loadOp(LB, 12'h012, 1'b0, 32'h0000_0022, 2'b00);
         storeOp(LB, 12'h010, 32'h0000_0080, 1'b0, 2'b00);
         loadOp(LB, 12'h010, 1'b0, 32'hFFFF_FF80, 2'b00);
         drain();
      end

      $display("[TB] reset while waiting for a response");
      sel = 2'd1;
      @(posedge clk); #1;
      applyStimulus(1'b0, LW, 12'h010, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_wait_req_ready", {31'b0, cur_req_ready}, 32'd1);
      checkOutput("rst_wait_resp_valid", {31'b0, cur_resp_valid}, 32'd0);
      repeat (12) @(posedge clk);
      #1;
      loadOp(LW, 12'h010, 1'b0, 32'h1122_3380, 2'b00);
      drain();

      $display("[TB] out-of-range on 256-word instance");
      sel = 2'd3;
      @(posedge clk); #1;
      loadOp(LW, 12'h800, 1'b0, 32'h0, 2'b10);
      loadOp(LW, 12'h800, 1'b1, 32'h0, 2'b10);
      loadOp(LH, 12'h801, 1'b1, 32'h0, 2'b01);
      storeOp(LW, 12'h3FC, 32'h0BAD_F00D, 1'b0, 2'b00);
      loadOp(LW, 12'h3FC, 1'b0, 32'h0BAD_F00D, 2'b00);
      drain();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
